// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

    // Default geometry of the data memory (256 x 8)
    localparam int unsigned DMEM_ADDR_W = 8;
    localparam int unsigned DMEM_DATA_W = 8;

    // Port identifiers as carried on grant_b
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Sequencer states; encoding is fixed so waveforms stay readable
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } dmem_state_e;

    // Round-robin pick on a tie: hand the grant to the port that did not have it last
    function automatic logic rr_next(input logic last_grant_b);
        return (last_grant_b == PORT_B) ? PORT_A : PORT_B;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way request arbiter: round-robin on ties unless port A is given fixed priority.
// Purely combinational; the caller owns the last-grant register.
module rr_arbiter2
    import dmem_pkg::*;
#(
    parameter bit FIXED_PRIO_A = 1'b0
) (
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant_b,
    output logic gnt_valid,
    output logic gnt_b
);

    // Winner selection for the current request pair
    always_comb begin
        gnt_valid = req_a | req_b;
        gnt_b     = PORT_A;
        unique case ({req_a, req_b})
            2'b01:   gnt_b = PORT_B;
            2'b10:   gnt_b = PORT_A;
            2'b11:   gnt_b = FIXED_PRIO_A ? PORT_A : rr_next(last_grant_b);
            default: gnt_b = PORT_A;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer in front of the 256x8 data memory.
// Port A is the CPU load/store path, port B the DMA/loader path. Exactly one access
// is in flight: IDLE (arbitrate + latch) -> ACCESS (drive memory) -> DONE (ack).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter bit          FIXED_PRIO_A = 1'b0,
    parameter int unsigned ADDR_W       = DMEM_ADDR_W,
    parameter int unsigned DATA_W       = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,

    output logic              busy,
    output logic              grant_b
);

    dmem_state_e       state_q;

    // Transaction captured at the IDLE edge; inputs may wiggle freely before that
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              grant_b_q;

    logic              gnt_valid;
    logic              gnt_b;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    rr_arbiter2 #(
        .FIXED_PRIO_A (FIXED_PRIO_A)
    ) u_arb (
        .req_a        (a_req),
        .req_b        (b_req),
        .last_grant_b (grant_b_q),
        .gnt_valid    (gnt_valid),
        .gnt_b        (gnt_b)
    );

    // Route the winning port's request fields toward the latch
    always_comb begin
        win_we    = a_we;
        win_addr  = a_addr;
        win_wdata = a_wdata;
        if (gnt_b == PORT_B) begin
            win_we    = b_we;
            win_addr  = b_addr;
            win_wdata = b_wdata;
        end
    end

    // Sequencer: state, transaction latch, memory strobes, acks and read-data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            grant_b_q <= PORT_B;  // so A wins the first tie
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                    if (gnt_valid) begin
                        we_q      <= win_we;
                        addr_q    <= win_addr;
                        wdata_q   <= win_wdata;
                        grant_b_q <= gnt_b;
                        // Strobes are registered so they are high for ACCESS only
                        mem_read  <= ~win_we;
                        mem_write <= win_we;
                        state_q   <= StAccess;
                    end
                end

                StAccess: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    // Memory is combinational in address, so data is valid at this edge
                    if (!we_q) begin
                        if (grant_b_q == PORT_B) begin
                            b_rdata <= mem_read_data;
                        end else begin
                            a_rdata <= mem_read_data;
                        end
                    end
                    if (grant_b_q == PORT_B) begin
                        b_ack <= 1'b1;
                    end else begin
                        a_ack <= 1'b1;
                    end
                    state_q <= StDone;
                end

                StDone: begin
                    a_ack   <= 1'b0;
                    b_ack   <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    a_ack     <= 1'b0;
                    b_ack     <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    // Address and write data come straight from the latched transaction
    always_comb begin
        mem_address    = addr_q;
        mem_write_data = wdata_q;
        busy           = (state_q != StIdle);
        grant_b        = grant_b_q;
    end

`ifndef SYNTHESIS
    // Never read and write in the same cycle
    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_read && mem_write));

    // Only one port is ever acknowledged at a time
    a_ack_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(a_ack && b_ack));

    // Every memory strobe is followed by an acknowledge in the next cycle
    a_strobe_then_ack: assert property (@(posedge clk) disable iff (!rst_n)
        (mem_read || mem_write) |=> (a_ack || b_ack));

    // Strobes only appear while busy
    a_strobe_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (mem_read || mem_write) |-> busy);
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural 256x8 memory, scoreboard of expected completions,
// plus a fixed-priority instance sharing the requester inputs for the contention case.
module tb_dmem_arbiter;

    logic       clk;
    logic       rst_n;
    logic       preload;

    logic       a_req, a_we, b_req, b_we;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;

    // Round-robin instance
    logic       a_ack, b_ack, mem_read, mem_write, busy, grant_b;
    logic [7:0] a_rdata, b_rdata, mem_address, mem_write_data, mem_read_data;

    // Fixed-priority instance
    logic       a_ack1, b_ack1, mem_read1, mem_write1, busy1, grant_b1;
    logic [7:0] a_rdata1, b_rdata1, mem_address1, mem_write_data1, mem_read_data1;

    logic [7:0] mem [256];

    typedef struct {
        logic       pb;
        logic       we;
        logic [7:0] rd;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int a_ack_cnt = 0, b_ack_cnt = 0, wr_cnt = 0, rd_cnt = 0;
    int a1_cnt = 0, b1_cnt = 0;

    dmem_arbiter #(.FIXED_PRIO_A(1'b0), .ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .busy(busy), .grant_b(grant_b)
    );

    dmem_arbiter #(.FIXED_PRIO_A(1'b1), .ADDR_W(8), .DATA_W(8)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack1), .a_rdata(a_rdata1),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack1), .b_rdata(b_rdata1),
        .mem_read(mem_read1), .mem_write(mem_write1), .mem_address(mem_address1),
        .mem_write_data(mem_write_data1), .mem_read_data(mem_read_data1),
        .busy(busy1), .grant_b(grant_b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational read; idle bus modelled as zero
    assign mem_read_data  = mem_read  ? mem[mem_address]  : 8'h00;
    assign mem_read_data1 = mem_read1 ? mem[mem_address1] : 8'h00;

    // Only the round-robin instance writes the shared array
    always @(posedge clk) begin
        if (preload) begin
            mem[8'h00] <= 8'h5A;
            mem[8'h04] <= 8'h12;
        end else if (mem_write) begin
            mem[mem_address] <= mem_write_data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Completion monitor: pops the scoreboard on every ack of the round-robin instance
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_ack)     a_ack_cnt <= a_ack_cnt + 1;
            if (b_ack)     b_ack_cnt <= b_ack_cnt + 1;
            if (mem_write) wr_cnt    <= wr_cnt + 1;
            if (mem_read)  rd_cnt    <= rd_cnt + 1;
            if (a_ack1)    a1_cnt    <= a1_cnt + 1;
            if (b_ack1)    b1_cnt    <= b1_cnt + 1;
            if (a_ack || b_ack) begin
                check_eq("ack_onehot", 32'(a_ack & b_ack), 32'd0);
                check_eq("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("ack_port", 32'(b_ack), 32'(e.pb));
                    if (!e.we) begin
                        check_eq("rdata", 32'(e.pb ? b_rdata : a_rdata), 32'(e.rd));
                    end
                end
            end
        end
    end

    task automatic set_req(input logic pb, input logic v, input logic we,
                           input logic [7:0] addr, input logic [7:0] wdata);
        if (pb) begin
            b_req = v; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = v; a_we = we; a_addr = addr; a_wdata = wdata;
        end
    endtask

    // Uncontended access with cycle-exact checks; starts and ends at a negedge in IDLE
    task automatic access(input logic pb, input logic we, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [7:0] rd_exp);
        sb.push_back('{pb: pb, we: we, rd: rd_exp});
        set_req(pb, 1'b1, we, addr, wdata);
        @(negedge clk);  // ACCESS
        check_eq("acc_busy", 32'(busy), 32'd1);
        check_eq("acc_rd", 32'(mem_read), 32'(!we));
        check_eq("acc_wr", 32'(mem_write), 32'(we));
        check_eq("acc_addr", 32'(mem_address), 32'(addr));
        if (we) check_eq("acc_wdata", 32'(mem_write_data), 32'(wdata));
        check_eq("acc_grant", 32'(grant_b), 32'(pb));
        check_eq("acc_noack", 32'({a_ack, b_ack}), 32'd0);
        @(negedge clk);  // DONE
        check_eq("done_ack", 32'({a_ack, b_ack}), pb ? 32'd1 : 32'd2);
        check_eq("done_strobes", 32'({mem_read, mem_write}), 32'd0);
        check_eq("done_busy", 32'(busy), 32'd1);
        set_req(pb, 1'b0, we, addr, wdata);
        @(negedge clk);  // IDLE
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_noack", 32'({a_ack, b_ack}), 32'd0);
    endtask

    task automatic wait_ack(input logic pb, input int maxc, output int n);
        n = 0;
        while (!(pb ? b_ack : a_ack) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check_eq("ack_in_time", 32'(n < maxc), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n0, n1, sa, sb0, sa1, sb1, sw;
        rst_n = 1'b0; preload = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        @(negedge clk);
        @(negedge clk);
        preload = 1'b0;
        // Reset state
        check_eq("rst_strobes", 32'({mem_read, mem_write, a_ack, b_ack, busy}), 32'd0);
        check_eq("rst_addr", 32'({mem_address, mem_write_data}), 32'd0);
        check_eq("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
        check_eq("rst_grant", 32'(grant_b), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single A read
        sb0 = b_ack_cnt; sw = rd_cnt;
        access(1'b0, 1'b0, 8'h04, 8'h00, 8'h12);
        check_eq("single_a_rdata", 32'(a_rdata), 32'h12);
        check_eq("single_no_back", 32'(b_ack_cnt - sb0), 32'd0);
        check_eq("single_rd_cycles", 32'(rd_cnt - sw), 32'd1);

        // B write then A read of the same location
        sw = wr_cnt;
        access(1'b1, 1'b1, 8'h10, 8'hA5, 8'h00);
        check_eq("bwr_wr_cycles", 32'(wr_cnt - sw), 32'd1);
        access(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
        check_eq("bwr_a_rdata", 32'(a_rdata), 32'hA5);

        // Simultaneous from reset: A first, B three cycles later
        do_reset();
        sb.push_back('{pb: 1'b0, we: 1'b0, rd: 8'h12});
        sb.push_back('{pb: 1'b1, we: 1'b1, rd: 8'h00});
        set_req(1'b0, 1'b1, 1'b0, 8'h04, 8'h00);
        set_req(1'b1, 1'b1, 1'b1, 8'h20, 8'h3C);
        wait_ack(1'b0, 10, n0);
        check_eq("sim_a_latency", 32'(n0), 32'd2);
        check_eq("sim_a_first", 32'(b_ack), 32'd0);
        a_req = 1'b0;
        wait_ack(1'b1, 10, n1);
        check_eq("sim_b_gap", 32'(n1), 32'd3);
        b_req = 1'b0;
        @(negedge clk);
        check_eq("sim_mem20", 32'(mem[8'h20]), 32'h3C);
        check_eq("sim_a_rdata", 32'(a_rdata), 32'h12);

        // Continuous contention for 12 cycles: RR alternates, fixed priority keeps A
        do_reset();
        sa = a_ack_cnt; sb0 = b_ack_cnt; sa1 = a1_cnt; sb1 = b1_cnt;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{pb: logic'(i % 2), we: 1'b0, rd: 8'h12});
        end
        set_req(1'b0, 1'b1, 1'b0, 8'h04, 8'h00);
        set_req(1'b1, 1'b1, 1'b0, 8'h04, 8'h00);
        repeat (12) @(negedge clk);
        a_req = 1'b0; b_req = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rr_a_grants", 32'(a_ack_cnt - sa), 32'd2);
        check_eq("rr_b_grants", 32'(b_ack_cnt - sb0), 32'd2);
        check_eq("fp_a_grants", 32'(a1_cnt - sa1), 32'd4);
        check_eq("fp_b_grants", 32'(b1_cnt - sb1), 32'd0);
        check_eq("fp_a_rdata", 32'(a_rdata1), 32'h12);

        // Reset in the middle of B's write ACCESS
        sb0 = b_ack_cnt;
        set_req(1'b1, 1'b1, 1'b1, 8'h30, 8'h77);
        @(posedge clk);
        #1;
        check_eq("mid_wr_high", 32'(mem_write), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_strobes", 32'({mem_read, mem_write, a_ack, b_ack, busy}), 32'd0);
        check_eq("mid_addr", 32'({mem_address, mem_write_data}), 32'd0);
        check_eq("mid_rdata", 32'({a_rdata, b_rdata}), 32'd0);
        b_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("mid_no_back", 32'(b_ack_cnt - sb0), 32'd0);
        access(1'b0, 1'b0, 8'h04, 8'h00, 8'h12);

        // Boundary addresses
        access(1'b0, 1'b1, 8'hFF, 8'hFF, 8'h00);
        access(1'b0, 1'b0, 8'hFF, 8'h00, 8'hFF);
        check_eq("bnd_ff", 32'(a_rdata), 32'hFF);
        access(1'b0, 1'b0, 8'h00, 8'h00, 8'h5A);
        check_eq("bnd_00", 32'(a_rdata), 32'h5A);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
